// File: rtl/regfile_sb_pkg.sv
// Shared defaults and register-file typedefs for regfile_sb.
// Holds no logic. Latency and backpressure are defined by regfile_sb and its scoreboard.
package regfile_sb_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int NREAD_DEF = 2;

    typedef logic [$clog2(DEPTH_DEF)-1:0] reg_addr_t;
    typedef logic [WIDTH_DEF-1:0]         reg_data_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Bundles decode (issue/read) and writeback signals for regfile_sb.
// The master side drives requests. The slave side is the register file, which returns data, busy bits and issue_ready.
interface regfile_sb_if #(
    parameter int WIDTH = regfile_sb_pkg::WIDTH_DEF,
    parameter int DEPTH = regfile_sb_pkg::DEPTH_DEF,
    parameter int NREAD = regfile_sb_pkg::NREAD_DEF
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   we;
    logic [AW-1:0]          wa;
    logic [WIDTH-1:0]       wd;
    logic [NREAD*AW-1:0]    ra;
    logic [NREAD*WIDTH-1:0] rd;
    logic [NREAD-1:0]       rbusy;
    logic                   issue_valid;
    logic [AW-1:0]          issue_dst;
    logic                   issue_ready;
    logic [CW-1:0]          pending_cnt;

    modport master (
        output we, wa, wd, ra, issue_valid, issue_dst,
        input  rd, rbusy, issue_ready, pending_cnt
    );

    modport slave (
        input  we, wa, wd, ra, issue_valid, issue_dst,
        output rd, rbusy, issue_ready, pending_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Tracks one pending-write busy bit per register and counts the busy registers. issue_ready and rbusy are combinational.
// Busy state updates one cycle after issue. issue_ready drops on a WAW hazard and does not depend on issue_valid.
module regfile_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_dst,
    input  logic [NREAD*AW-1:0] ra,
    output logic              issue_ready,
    output logic [NREAD-1:0]  rbusy,
    output logic [CW-1:0]     pending_cnt
);
    localparam bit ZR = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy;
    logic             clr;
    logic             dst_zero;
    logic             set_eff;

    assign clr         = we & busy[wa];
    assign dst_zero    = ZR && (issue_dst == '0);
    assign issue_ready = dst_zero | ~busy[issue_dst] | (clr & (wa == issue_dst));
    assign set_eff     = issue_valid & issue_ready & ~dst_zero;

    // The set is applied after the clear, so a new producer on the same register wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            if (clr)
                busy[wa] <= 1'b0;
            if (set_eff)
                busy[issue_dst] <= 1'b1;
            case ({set_eff, clr})
                2'b10:   pending_cnt <= pending_cnt + CW'(1);
                2'b01:   pending_cnt <= pending_cnt - CW'(1);
                default: pending_cnt <= pending_cnt;
            endcase
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rbusy
        logic [AW-1:0] a;
        assign a        = ra[i*AW +: AW];
        assign rbusy[i] = busy[a] & ~(clr & (wa == a)) & ~(ZR && (a == '0));
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a write-pending scoreboard. Reads are combinational and writes land on the clock edge.
// No backpressure on writeback. Decode stalls on issue_ready/rbusy. REGFILE_SB_BYPASS_EN adds same-cycle write-to-read bypass.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NREAD    = NREAD_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    regfile_sb_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam bit ZR = (ZERO_REG != 0);

    logic [WIDTH-1:0] rf [DEPTH];
    logic             wa_zero;

    assign wa_zero = ZR && (bus.wa == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                rf[i] <= '0;
        end else if (bus.we && !wa_zero) begin
            rf[bus.wa] <= bus.wd;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] a;
        logic          a_zero;
        assign a      = bus.ra[i*AW +: AW];
        assign a_zero = ZR && (a == '0);
`ifdef REGFILE_SB_BYPASS_EN
        assign bus.rd[i*WIDTH +: WIDTH] = a_zero ? '0 :
                                          (bus.we && !wa_zero && (bus.wa == a)) ? bus.wd : rf[a];
`else
        assign bus.rd[i*WIDTH +: WIDTH] = a_zero ? '0 : rf[a];
`endif
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NREAD    (NREAD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk         (clk),
        .reset_n     (reset_n),
        .we          (bus.we),
        .wa          (bus.wa),
        .issue_valid (bus.issue_valid),
        .issue_dst   (bus.issue_dst),
        .ra          (bus.ra),
        .issue_ready (bus.issue_ready),
        .rbusy       (bus.rbusy),
        .pending_cnt (bus.pending_cnt)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with default parameters. Inputs change 1 time unit after posedge, and outputs are checked on negedge.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    regfile_sb_if #(.WIDTH(32), .DEPTH(32), .NREAD(2)) bus ();

    regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic w, input reg_addr_t a, input reg_data_t d);
        bus.we = w;
        bus.wa = a;
        bus.wd = d;
    endtask

    task automatic iss(input logic v, input reg_addr_t a);
        bus.issue_valid = v;
        bus.issue_dst   = a;
    endtask

    task automatic rd_addr(input reg_addr_t a0, input reg_addr_t a1);
        bus.ra = {a1, a0};
    endtask

    function automatic reg_data_t rd_port(input int i);
        return bus.rd[i*32 +: 32];
    endfunction

    initial begin
        reset_n = 1'b0;
        wr(0, 0, 0);
        iss(0, 0);
        rd_addr(5, 31);
        tick();
        tick();
        reset_n = 1'b1;

        // 1: reset state, then basic write/read
        @(negedge clk);
        check("rst_rd0", rd_port(0), 0);
        check("rst_rd1", rd_port(1), 0);
        check("rst_rbusy", bus.rbusy, 0);
        check("rst_pcnt", bus.pending_cnt, 0);
        tick();
        wr(1, 5, 32'hDEADBEEF);
        tick();
        wr(0, 0, 0);
        @(negedge clk);
        check("wr5_rd0", rd_port(0), 32'hDEADBEEF);

        // 2: register 0 is hardwired
        tick();
        wr(1, 0, 32'h1234);
        rd_addr(0, 5);
        iss(1, 0);
        @(negedge clk);
        check("r0_ready", bus.issue_ready, 1);
        tick();
        wr(0, 0, 0);
        iss(0, 0);
        @(negedge clk);
        check("r0_rd0", rd_port(0), 0);
        check("r0_pcnt", bus.pending_cnt, 0);
        check("r0_rbusy", bus.rbusy[0], 0);

        // 3: issue, WAW stall, then writeback clears
        tick();
        rd_addr(0, 7);
        iss(1, 7);
        @(negedge clk);
        check("r7_pre_rbusy", bus.rbusy[1], 0);
        tick();
        @(negedge clk);
        check("r7_pcnt1", bus.pending_cnt, 1);
        check("r7_rbusy", bus.rbusy[1], 1);
        check("r7_waw_ready", bus.issue_ready, 0);
        tick();
        iss(0, 7);
        wr(1, 7, 32'hA5);
        @(negedge clk);
        check("r7_clr_rbusy", bus.rbusy[1], 0);
        check("r7_clr_ready", bus.issue_ready, 1);
        check("r7_pcnt_hold", bus.pending_cnt, 1);
        tick();
        wr(0, 0, 0);
        @(negedge clk);
        check("r7_pcnt0", bus.pending_cnt, 0);
        check("r7_rd1", rd_port(1), 32'hA5);

        // 4: issue and write in the same cycle
        tick();
        iss(1, 9);
        tick();
        iss(1, 9);
        wr(1, 9, 32'h99);
        rd_addr(9, 3);
        @(negedge clk);
        check("r9_ready", bus.issue_ready, 1);
        check("r9_clr_rbusy", bus.rbusy[0], 0);
        tick();
        iss(0, 0);
        wr(0, 0, 0);
        @(negedge clk);
        check("r9_still_busy", bus.rbusy[0], 1);
        check("r9_pcnt", bus.pending_cnt, 1);
        check("r9_rd0", rd_port(0), 32'h99);
        tick();
        iss(1, 3);
        wr(1, 9, 32'h33);
        @(negedge clk);
        check("r3r9_ready", bus.issue_ready, 1);
        tick();
        iss(0, 0);
        wr(0, 0, 0);
        @(negedge clk);
        check("r3r9_pcnt", bus.pending_cnt, 1);
        check("r9_free", bus.rbusy[0], 0);
        check("r3_busy", bus.rbusy[1], 1);

        // 5: write-to-read bypass
        tick();
        wr(1, 4, 32'h11);
        tick();
        wr(1, 4, 32'h55);
        rd_addr(0, 4);
        @(negedge clk);
`ifdef REGFILE_SB_BYPASS_EN
        check("byp_rd1", rd_port(1), 32'h55);
`else
        check("nobyp_rd1", rd_port(1), 32'h11);
`endif
        check("byp_rd0_zero", rd_port(0), 0);
        tick();
        wr(0, 0, 0);
        @(negedge clk);
        check("r4_rd1", rd_port(1), 32'h55);

        // 6: reset mid-operation overrides write and issue
        tick();
        iss(1, 10);
        tick();
        iss(1, 11);
        tick();
        iss(0, 0);
        @(negedge clk);
        check("pre_rst_pcnt", bus.pending_cnt, 3);
        tick();
        reset_n = 1'b0;
        wr(1, 12, 32'hFF);
        iss(1, 13);
        tick();
        reset_n = 1'b1;
        wr(0, 0, 0);
        iss(0, 13);
        rd_addr(5, 4);
        @(negedge clk);
        check("mrst_rd5", rd_port(0), 0);
        check("mrst_rd4", rd_port(1), 0);
        check("mrst_pcnt", bus.pending_cnt, 0);
        check("mrst_ready13", bus.issue_ready, 1);
        tick();
        rd_addr(3, 10);
        @(negedge clk);
        check("mrst_rbusy", bus.rbusy, 0);
        tick();
        rd_addr(12, 11);
        @(negedge clk);
        check("mrst_rd12", rd_port(0), 0);
        check("mrst_rbusy11", bus.rbusy[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised multi-read-port register file for the pipelined datapath. Generalises width, depth and read-port count. Adds a synchronous clear and a per-register scoreboard (pending-write busy bits) with an issue handshake, so decode can stall on RAW/WAW hazards. Sits between decode (issue/read) and writeback (write port).

Parameters:
WIDTH, 32, data bits per register
DEPTH, 32, number of registers (power of two, >=2)
NREAD, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy
(localparam AW = $clog2(DEPTH); CW = $clog2(DEPTH+1))

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk
we  input  1  writeback write enable
wa  input  AW  writeback address
wd  input  WIDTH  writeback data
ra  input  NREAD*AW  packed read addresses; port i = ra[i*AW +: AW]
rd  output  NREAD*WIDTH  packed read data; port i = rd[i*WIDTH +: WIDTH]
rbusy  output  NREAD  port i: register ra[i] has a pending write
issue_valid  input  1  decode requests to mark issue_dst busy
issue_dst  input  AW  destination register of the issuing instruction
issue_ready  output  1  issue may be accepted this cycle
pending_cnt  output  CW  number of registers currently busy

Behaviour:
- Reset: on posedge with reset_n=0, all registers <= 0, all busy bits <= 0, pending_cnt <= 0. Reset overrides we and issue in the same cycle. rd follows the cleared contents, and rbusy=0, from the next cycle.
- Write: at posedge, if we=1 and not (ZERO_REG=1 and wa=0), rf[wa] <= wd. Otherwise rf is unchanged.
- Read: combinational, zero latency. rd[i] = 0 if ZERO_REG=1 and ra[i]=0; else rf[ra[i]]. Without the optional feature, same-cycle write data is not visible until the next cycle.
- Scoreboard:
  - accept = issue_valid & issue_ready.
  - clr = we & busy[wa].
  - At posedge: busy[issue_dst] <= 1 on accept; busy[wa] <= 0 on clr.
  - If both hit the same address, set wins: a new producer replaces the old one.
  - Issue to register 0 with ZERO_REG=1: accepted, but no bit is set.
  - A write to a non-busy register is legal and leaves the scoreboard unchanged.
- issue_ready:
  - 1 if issue_dst is not busy, or a clr targets issue_dst this cycle.
  - 0 otherwise (WAW stall).
  - Always 1 for register 0 when ZERO_REG=1.
  - issue_ready must not depend on issue_valid.
- rbusy[i] = busy[ra[i]] & ~(clr & wa==ra[i]). Forced to 0 for register 0 when ZERO_REG=1.
- pending_cnt: +1 on an effective set, -1 on an effective clear, unchanged when both occur (different addresses, or same address where set wins). Never wraps: the range is 0..DEPTH by construction.
- All four combinations of we/issue occurring together in one cycle must be handled.

Optional Feature:
REGFILE_SB_BYPASS_EN.
- Defined: write-to-read bypass. If we=1, wa==ra[i], and not (ZERO_REG and wa=0), then rd[i] = wd in the same cycle. rbusy already reflects the clear.
- Undefined: no bypass; rd shows the old contents. Decode must stall one extra cycle after the clear before reading.

Decomposition:
- Package regfile_sb_pkg holds the default WIDTH/DEPTH/NREAD constants and the typedefs reg_addr_t and reg_data_t.
- Natural sub-module: regfile_scoreboard, holding the busy vector, issue_ready, rbusy and pending_cnt. The data array and read muxing stay in regfile_sb.

Test Plan:
1. Reset, then read all ports -> rd=0, rbusy=0, pending_cnt=0. Then we=1, wa=5, wd=32'hDEADBEEF; next cycle ra0=5 -> rd0=32'hDEADBEEF.
2. we=1, wa=0, wd=32'h1234 with ZERO_REG=1 -> rd for ra=0 stays 0. Issue_dst=0 -> issue_ready=1, pending_cnt stays 0.
3. Issue r7 -> pending_cnt=1, rbusy for ra=7 =1. Second issue r7 -> issue_ready=0. Write r7=32'hA5 -> busy clears, pending_cnt=0.
4. Same cycle: issue r9 (busy) plus write r9 -> issue_ready=1, r9 still busy after the edge, pending_cnt unchanged. Issue r3 plus write r9 -> pending_cnt unchanged.
5. With REGFILE_SB_BYPASS_EN: write wa=4, wd=32'h55 with ra1=4 in the same cycle -> rd1=32'h55 that cycle. Without the macro -> rd1 shows the old value.
6. Reset mid-operation: 3 registers busy and 2 written, then assert reset_n=0 together with we=1 and issue_valid=1 -> next cycle all rd=0, rbusy=0, pending_cnt=0.
